// File: rtl/account_display.sv
// Five-digit multiplexed 7-segment driver for the call-billing display: balance (yuan.jiao fen)
// and elapsed minutes, with frame-synchronous snapshotting, low-balance flashing and line-cut dashes.
module account_display (
    input  logic        clk_1kHz,
    input  logic        clr,
    input  logic [7:0]  disptime,
    input  logic [11:0] dispmoney,
    input  logic        warn,
    input  logic        cut,
    output logic [7:0]  seg,
    output logic [4:0]  an,
    output logic        frame
);

    typedef enum logic [2:0] {
        DIG_FEN   = 3'd0,
        DIG_JIAO  = 3'd1,
        DIG_YUAN  = 3'd2,
        DIG_MIN_U = 3'd3,
        DIG_MIN_T = 3'd4
    } digit_e;

    localparam logic [7:0] BLINK_LAST = 8'd249;

    digit_e      scan_q, scan_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [7:0]  snap_time_q, snap_time_d;
    logic [11:0] snap_money_q, snap_money_d;
    logic        snap_warn_q, snap_warn_d;
    logic        snap_cut_q, snap_cut_d;
    logic        frame_q, frame_d;
    logic [7:0]  seg_q, seg_d;
    logic [4:0]  an_q, an_d;

    logic        scan_wrap;
    logic [3:0]  nibble;
    logic        money_digit;

    function automatic logic [7:0] seven_seg(input logic [3:0] v);
        case (v)
            4'd0:    seven_seg = 8'h3F;
            4'd1:    seven_seg = 8'h06;
            4'd2:    seven_seg = 8'h5B;
            4'd3:    seven_seg = 8'h4F;
            4'd4:    seven_seg = 8'h66;
            4'd5:    seven_seg = 8'h6D;
            4'd6:    seven_seg = 8'h7D;
            4'd7:    seven_seg = 8'h07;
            4'd8:    seven_seg = 8'h7F;
            4'd9:    seven_seg = 8'h6F;
            default: seven_seg = 8'h79;
        endcase
    endfunction

    always_comb begin
        scan_d        = scan_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        snap_time_d   = snap_time_q;
        snap_money_d  = snap_money_q;
        snap_warn_d   = snap_warn_q;
        snap_cut_d    = snap_cut_q;
        frame_d       = 1'b0;
        nibble        = '0;
        money_digit   = 1'b0;

        scan_wrap = (scan_q == DIG_MIN_T);
        scan_d    = scan_wrap ? DIG_FEN : digit_e'(scan_q + 3'd1);

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + 8'd1;
        end

        if (scan_wrap) begin
            snap_time_d  = disptime;
            snap_money_d = dispmoney;
            snap_warn_d  = warn;
            snap_cut_d   = cut;
            frame_d      = 1'b1;
        end

        case (scan_q)
            DIG_FEN:   begin nibble = snap_money_q[3:0];  money_digit = 1'b1; end
            DIG_JIAO:  begin nibble = snap_money_q[7:4];  money_digit = 1'b1; end
            DIG_YUAN:  begin nibble = snap_money_q[11:8]; money_digit = 1'b1; end
            DIG_MIN_U: nibble = snap_time_q[3:0];
            DIG_MIN_T: nibble = snap_time_q[7:4];
            default:   nibble = '0;
        endcase

        // Override order, weakest first: glyph, decimal point, tens blanking, flash, line cut.
        seg_d = seven_seg(nibble);
        if (scan_q == DIG_YUAN)
            seg_d = seg_d | 8'h80;
        if (scan_q == DIG_MIN_T && nibble == 4'd0)
            seg_d = '0;
        if (money_digit && snap_warn_q && blink_phase_q)
            seg_d = '0;
        if (snap_cut_q)
            seg_d = 8'h40;

        an_d = ~(5'b00001 << scan_q);

        if (clr) begin
            scan_d        = DIG_FEN;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
            snap_time_d   = '0;
            snap_money_d  = '0;
            snap_warn_d   = 1'b0;
            snap_cut_d    = 1'b0;
            frame_d       = 1'b0;
            seg_d         = '0;
            an_d          = '1;
        end
    end

    always_ff @(posedge clk_1kHz) begin
        scan_q        <= scan_d;
        blink_cnt_q   <= blink_cnt_d;
        blink_phase_q <= blink_phase_d;
        snap_time_q   <= snap_time_d;
        snap_money_q  <= snap_money_d;
        snap_warn_q   <= snap_warn_d;
        snap_cut_q    <= snap_cut_d;
        frame_q       <= frame_d;
        seg_q         <= seg_d;
        an_q          <= an_d;
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
